// File: rtl/twf_mul_seq_ctrl.sv
// Beat/frame sequencer for the 8-lane twiddle multiplier: drives en/select and frame-aligned output flags.
// Optional `TWF_CTRL_FRAME_CNT_EN builds the 16-bit completed-frame counter; otherwise frame_cnt is tied to 0.
module twf_mul_seq_ctrl #(
  parameter int BEATS_PER_FRAME = 16,
  parameter int SEL_HOLD        = 2,
  parameter int CNT_W           = $clog2(BEATS_PER_FRAME)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_valid,
  input  logic        din_frame_start,
  output logic        en,
  output logic        select,
  output logic        dout_valid,
  output logic        dout_frame_start,
  output logic        dout_frame_end,
  output logic        frame_done,
  output logic        busy,
  output logic        err_sof,
  output logic        err_orphan,
  output logic [15:0] frame_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] HOLD     = CNT_W'(SEL_HOLD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0] cur_idx, sel_grp;
  logic             acc, last_beat;

  logic dv_q, dv_d;
  logic fs_q, fs_d;
  logic fe_q, fe_d;
  logic sof_q, sof_d;
  logic orph_q, orph_d;

  // A frame start always restarts indexing at 0, even mid-frame.
  assign acc       = din_valid && (din_frame_start || (state_q == S_RUN));
  assign cur_idx   = din_frame_start ? '0 : beat_idx_q;
  assign last_beat = acc && (cur_idx == LAST_IDX);
  assign sel_grp   = cur_idx / HOLD;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_idx_q <= '0;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      sof_q      <= 1'b0;
      orph_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      sof_q      <= sof_d;
      orph_q     <= orph_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    if (acc) begin
      if (cur_idx == LAST_IDX) begin
        state_d    = S_IDLE;
        beat_idx_d = '0;
      end else begin
        state_d    = S_RUN;
        beat_idx_d = cur_idx + 1'b1;
      end
    end
  end

  // Output logic: en/select are live, the rest line up with the product register
  always_comb begin
    en     = rst_n && acc;
    select = rst_n && acc && sel_grp[0];
    dv_d   = acc;
    fs_d   = acc && (cur_idx == '0);
    fe_d   = last_beat;
    sof_d  = din_valid && din_frame_start && (state_q == S_RUN) && (beat_idx_q != '0);
    orph_d = din_valid && !din_frame_start && (state_q == S_IDLE);
  end

  assign dout_valid       = dv_q;
  assign dout_frame_start = fs_q;
  assign dout_frame_end   = fe_q;
  assign frame_done       = fe_q;
  assign busy             = (state_q == S_RUN);
  assign err_sof          = sof_q;
  assign err_orphan       = orph_q;

`ifdef TWF_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts on the same edge that raises frame_done; aborted frames never reach last_beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame_cnt_q <= '0;
    else if (last_beat) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
